serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 123 ++++++++++++
 tb/tb_serial_subtractor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor. Computes {borrow, diff} = a - b - bin one bit per
//   clock, LSB first, using one borrow flip-flop in place of an n-stage borrow
//   chain. A start/busy/done handshake frames each operation.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   synchronous, active-low reset (takes priority over start)
//   start   in   request; only looked at while idle
//   a       in   [n-1:0] minuend, captured on the accepting edge
//   b       in   [n-1:0] subtrahend, captured on the accepting edge
//   bin     in   borrow-in, captured on the accepting edge
//   busy    out  high from the accepting edge until the edge after done
//   done    out  one-cycle pulse; diff/borrow hold the new result
//   diff    out  [n-1:0] registered difference, held until the next result
//   borrow  out  registered borrow-out, held until the next result
// ----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] diff,
    output logic         borrow
);

    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [n-1:0]   r_a;
    logic [n-1:0]   r_b;
    logic [n-1:0]   r_dsr;
    logic           r_br;
    logic [CW-1:0]  r_cnt;

    logic           w_a0;
    logic           w_b0;
    logic           w_d;
    logic           w_br_nxt;
    logic           w_last;
    logic [n-1:0]   w_dsr_nxt;

    // One full-subtractor slice on the current LSBs plus the stored borrow.
    always_comb begin
        w_a0     = r_a[0];
        w_b0     = r_b[0];
        w_d      = w_a0 ^ w_b0 ^ r_br;
        w_br_nxt = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
        w_last   = (r_cnt == CW'(n - 1));
        // Difference bits arrive LSB first, so they enter at the MSB and
        // drift down; after n shifts bit 0 sits at position 0.
        w_dsr_nxt        = r_dsr >> 1;
        w_dsr_nxt[n-1]   = w_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_dsr   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            borrow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        r_dsr   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_nxt;
                    r_dsr <= w_dsr_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    // Result outputs only move here, so they stay stable
                    // across idle time and the whole of the next operation.
                    if (w_last) begin
                        diff    <= w_dsr_nxt;
                        borrow  <= w_br_nxt;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// ----------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (n=4 main instance, n=1 second
//   instance). A transaction-level model predicts busy/done/diff/borrow every
//   cycle; directed, held-start, reset, random and exhaustive sequences are
//   applied and pinned with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         borrow;

    logic         start1;
    logic [0:0]   a1;
    logic [0:0]   b1;
    logic         bin1;
    logic         busy1;
    logic         done1;
    logic [0:0]   diff1;
    logic         borrow1;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor #(.n(N)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow)
    );

    serial_subtractor #(.n(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference a - b - bin modulo 2^(w+1), as an integer.
    function automatic int ref_sub(input int x, input int y, input int c, input int w);
        int r;
        r = x - y - c;
        if (r < 0) r = r + (1 << (w + 1));
        return r;
    endfunction

    // ---------------- transaction-level model of the n=4 instance ----------
    logic         m_busy, m_done, m_borrow;
    logic [N-1:0] m_diff;
    logic [N:0]   m_res;
    int           m_left;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_diff   <= '0;
            m_borrow <= 1'b0;
            m_left   <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_diff   <= m_res[N-1:0];
                m_borrow <= m_res[N];
                m_done   <= 1'b1;
            end
        end else if (start) begin
            m_busy <= 1'b1;
            m_left <= N;
            m_res  <= (N+1)'(ref_sub(int'(a), int'(b), int'(bin), N));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",   int'(busy),   int'(m_busy));
            chk("done",   int'(done),   int'(m_done));
            chk("diff",   int'(diff),   int'(m_diff));
            chk("borrow", int'(borrow), int'(m_borrow));
        end
    end

    // Starts an op on the n=4 instance from idle, waits for done, checks it.
    task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib,
                          input logic ibin, input int ed, input int eb,
                          input int gap);
        int lat;
        repeat (gap) @(negedge clk);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, N);
        chk("op_diff", int'(diff), ed);
        chk("op_borrow", int'(borrow), eb);
        @(negedge clk);
    endtask

    task automatic run_op1(input logic ia, input logic ib, input logic ibin);
        int lat;
        int r;
        a1 = ia; b1 = ib; bin1 = ibin; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 0;
        while (!done1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r = ref_sub(int'(ia), int'(ib), int'(ibin), 1);
        chk("n1_latency", lat, 1);
        chk("n1_diff", int'(diff1), r & 1);
        chk("n1_borrow", int'(borrow1), (r >> 1) & 1);
        @(negedge clk);
        chk("n1_idle", int'(busy1), 0);
    endtask

    initial begin
        int seen;
        logic [2*N:0] v;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_borrow", int'(borrow), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases with hand-computed results.
        run_op(4'd9,  4'd3,  1'b0, 6,  0, 0);
        run_op(4'd3,  4'd9,  1'b0, 10, 1, 1);
        run_op(4'd0,  4'd0,  1'b1, 15, 1, 0);
        run_op(4'd15, 4'd15, 1'b0, 0,  0, 2);

        // start held high, operands churning every cycle.
        seen = 0;
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
            @(negedge clk);
            if (done) seen++;
        end
        start = 1'b0;
        chk("b2b_dones", seen, 5);
        @(negedge clk);

        // Reset in the middle of an operation.
        a = 4'd12; b = 4'd5; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_diff", int'(diff), 0);
        chk("midrst_borrow", int'(borrow), 0);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("midrst_no_done", seen, 0);
        run_op(4'd7, 4'd2, 1'b1, 4, 0, 0);

        // Random operations with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            int ra, rb, rc, r;
            ra = int'($urandom_range(0, 15));
            rb = int'($urandom_range(0, 15));
            rc = int'($urandom_range(0, 1));
            r  = ref_sub(ra, rb, rc, N);
            run_op(N'(ra), N'(rb), 1'(rc), r % 16, r / 16,
                   int'($urandom_range(0, 2)));
        end

        // Exhaustive sweep, n=4.
        for (int i = 0; i < (1 << (2*N+1)); i++) begin
            int r;
            v = (2*N+1)'(i);
            r = ref_sub(int'(v[2*N:N+1]), int'(v[N:1]), int'(v[0]), N);
            run_op(v[2*N:N+1], v[N:1], v[0], r % 16, r / 16, 0);
        end

        // Exhaustive sweep, n=1.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] w;
            w = 3'(i);
            run_op1(w[2], w[1], w[0]);
        end

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
